// File: rtl/pl_ddr_rd_burst.sv
// pl_ddr_rd_burst
//   DDR read engine. A single start pulse with a byte address and byte length
//   is split into AXI4 INCR read bursts of at most BURST_BEATS beats (4 bytes
//   each) that never cross a 4 KB boundary. Only one burst is outstanding at a
//   time. Returned beats are re-registered onto a simple valid/data stream for
//   the consumer FIFO, and a one-cycle finish pulse reports completion.
//
// Optional feature macro: PL_DDR_RD_ERR_CHK_EN
//   When defined, pl_ddr_rd_err is a sticky flag set by a non-OKAY rresp or by
//   an rlast that disagrees with the engine's own beat count. It is cleared by
//   the next accepted start. When undefined the flag is tied to 0.
//
// Ports
//   pl_clk, rst_n                 clock, synchronous active-low reset
//   pl_ddr_rd_start/addr/length   request (addr and length 4-byte aligned)
//   pl_ddr_rd_finish              one-cycle completion pulse
//   pl_ddr_rd_busy                transfer in progress
//   pl_fifo_afull                 consumer almost-full, throttles m_rready
//   m_ar*                         AXI read address channel (size 4, INCR)
//   m_r*                          AXI read data channel
//   pl_ddr_rd_en/data             registered output beat stream
//   pl_ddr_rd_err                 sticky error flag
module pl_ddr_rd_burst #(
  parameter int DATA_W      = 32,
  parameter int BURST_BEATS = 16
) (
  input  logic              pl_clk,
  input  logic              rst_n,
  input  logic              pl_ddr_rd_start,
  input  logic [31:0]       pl_ddr_rd_addr,
  input  logic [31:0]       pl_ddr_rd_length,
  output logic              pl_ddr_rd_finish,
  output logic              pl_ddr_rd_busy,
  input  logic              pl_fifo_afull,
  output logic [31:0]       m_araddr,
  output logic [7:0]        m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              pl_ddr_rd_en,
  output logic [DATA_W-1:0] pl_ddr_rd_data,
  output logic              pl_ddr_rd_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         cur_addr_q, cur_addr_d;
  logic [31:0]         rem_beats_q, rem_beats_d;
  logic [8:0]          beat_cnt_q, beat_cnt_d;
  logic [7:0]          arlen_q, arlen_d;
  logic                zlen_q, zlen_d;
  logic                fin_q, fin_d;
  logic                en_q, en_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                rd_acc;
  logic [31:0]         rem_next;
  logic [31:0]         addr_next;
  logic [29:0]         start_beats;
  logic                unused_bits;

  // Beats of the next burst minus one: limited by the configured maximum, the
  // beats left in the transfer and the distance to the next 4 KB boundary.
  // Only called with rem != 0, so the result is at least one beat.
  function automatic logic [7:0] burst_len(input logic [31:0] addr,
                                           input logic [31:0] rem);
    logic [31:0] beats;
    logic [31:0] to_4k;
    to_4k = (32'd4096 - {20'd0, addr[11:0]}) >> 2;
    beats = 32'(BURST_BEATS);
    if (rem < beats)   beats = rem;
    if (to_4k < beats) beats = to_4k;
    return 8'(beats - 32'd1);
  endfunction

  assign start_beats = pl_ddr_rd_length[31:2];
  assign unused_bits = ^pl_ddr_rd_length[1:0];

  assign rd_acc    = m_rvalid && m_rready;
  assign rem_next  = rem_beats_q - 32'd1;
  assign addr_next = cur_addr_q + 32'd4;

  // rready depends only on the state register and afull so that a stall
  // takes effect in the very cycle afull rises.
  assign m_rready         = (state_q == DATA) && !pl_fifo_afull;
  assign m_arvalid        = (state_q == ADDR);
  assign m_araddr         = cur_addr_q;
  assign m_arlen          = arlen_q;
  assign pl_ddr_rd_busy   = (state_q != IDLE);
  assign pl_ddr_rd_finish = fin_q;
  assign pl_ddr_rd_en     = en_q;
  assign pl_ddr_rd_data   = data_q;

`ifdef PL_DDR_RD_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && pl_ddr_rd_start) begin
      err_d = 1'b0;
    end else if (state_q == DATA && rd_acc) begin
      // Burst end is owned by beat_cnt; rlast only has to agree with it.
      if (m_rresp != 2'b00 || m_rlast != (beat_cnt_q == 9'd1)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pl_clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign pl_ddr_rd_err = err_q;
`else
  logic unused_resp;
  assign unused_resp   = ^{m_rresp, m_rlast};
  assign pl_ddr_rd_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_beats_d = rem_beats_q;
    beat_cnt_d  = beat_cnt_q;
    arlen_d     = arlen_q;
    zlen_d      = zlen_q;
    fin_d       = 1'b0;
    en_d        = 1'b0;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (pl_ddr_rd_start) begin
          cur_addr_d  = pl_ddr_rd_addr;
          rem_beats_d = {2'b00, start_beats};
          if (start_beats == 30'd0) begin
            // Zero length still takes a DONE cycle; finish follows one later.
            state_d = DONE;
            zlen_d  = 1'b1;
          end else begin
            state_d = ADDR;
            zlen_d  = 1'b0;
            arlen_d = burst_len(pl_ddr_rd_addr, {2'b00, start_beats});
          end
        end
      end

      ADDR: begin
        if (m_arready) begin
          beat_cnt_d = {1'b0, arlen_q} + 9'd1;
          state_d    = DATA;
        end
      end

      DATA: begin
        if (rd_acc) begin
          beat_cnt_d  = beat_cnt_q - 9'd1;
          rem_beats_d = rem_next;
          cur_addr_d  = addr_next;
          en_d        = 1'b1;
          data_d      = m_rdata;
          if (beat_cnt_q == 9'd1) begin
            if (rem_next != 32'd0) begin
              state_d = ADDR;
              arlen_d = burst_len(addr_next, rem_next);
            end else begin
              state_d = DONE;
              fin_d   = 1'b1;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        fin_d   = zlen_q;
        zlen_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pl_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      rem_beats_q <= '0;
      beat_cnt_q  <= '0;
      arlen_q     <= '0;
      zlen_q      <= 1'b0;
      fin_q       <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_beats_q <= rem_beats_d;
      beat_cnt_q  <= beat_cnt_d;
      arlen_q     <= arlen_d;
      zlen_q      <= zlen_d;
      fin_q       <= fin_d;
      en_q        <= en_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_pl_ddr_rd_burst.sv
// Testbench for pl_ddr_rd_burst: a behavioural AXI slave plus a reference
// model of the burst split, beat ordering and completion timing.
module tb_pl_ddr_rd_burst;

  localparam int DATA_W      = 32;
  localparam int BURST_BEATS = 16;

`ifdef PL_DDR_RD_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        pl_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pl_ddr_rd_start = 1'b0;
  logic [31:0] pl_ddr_rd_addr  = '0;
  logic [31:0] pl_ddr_rd_length = '0;
  logic        pl_ddr_rd_finish;
  logic        pl_ddr_rd_busy;
  logic        pl_fifo_afull = 1'b0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata   = '0;
  logic [1:0]  m_rresp   = '0;
  logic        m_rlast   = 1'b0;
  logic        m_rvalid  = 1'b0;
  logic        m_rready;
  logic        pl_ddr_rd_en;
  logic [31:0] pl_ddr_rd_data;
  logic        pl_ddr_rd_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_len[$];

  always #5 pl_clk = ~pl_clk;

  pl_ddr_rd_burst #(.DATA_W(DATA_W), .BURST_BEATS(BURST_BEATS)) dut (
    .pl_clk           (pl_clk),
    .rst_n            (rst_n),
    .pl_ddr_rd_start  (pl_ddr_rd_start),
    .pl_ddr_rd_addr   (pl_ddr_rd_addr),
    .pl_ddr_rd_length (pl_ddr_rd_length),
    .pl_ddr_rd_finish (pl_ddr_rd_finish),
    .pl_ddr_rd_busy   (pl_ddr_rd_busy),
    .pl_fifo_afull    (pl_fifo_afull),
    .m_araddr         (m_araddr),
    .m_arlen          (m_arlen),
    .m_arvalid        (m_arvalid),
    .m_arready        (m_arready),
    .m_rdata          (m_rdata),
    .m_rresp          (m_rresp),
    .m_rlast          (m_rlast),
    .m_rvalid         (m_rvalid),
    .m_rready         (m_rready),
    .pl_ddr_rd_en     (pl_ddr_rd_en),
    .pl_ddr_rd_data   (pl_ddr_rd_data),
    .pl_ddr_rd_err    (pl_ddr_rd_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected AR sequence from plain arithmetic on the transfer parameters.
  task automatic build_ars(input logic [31:0] addr, input logic [31:0] len);
    longint a, rem, b, to4k;
    a   = addr;
    rem = len / 4;
    exp_addr.delete();
    exp_len.delete();
    while (rem > 0) begin
      b    = BURST_BEATS;
      to4k = (4096 - (a % 4096)) / 4;
      if (rem < b)  b = rem;
      if (to4k < b) b = to4k;
      exp_addr.push_back(32'(a));
      exp_len.push_back(32'(b - 1));
      a   = a + 4 * b;
      rem = rem - b;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arvalid"}, m_arvalid, 0);
    chk({tag, "_araddr"},  m_araddr, 0);
    chk({tag, "_arlen"},   m_arlen, 0);
    chk({tag, "_rready"},  m_rready, 0);
    chk({tag, "_en"},      pl_ddr_rd_en, 0);
    chk({tag, "_data"},    pl_ddr_rd_data, 0);
    chk({tag, "_finish"},  pl_ddr_rd_finish, 0);
    chk({tag, "_busy"},    pl_ddr_rd_busy, 0);
    chk({tag, "_err"},     pl_ddr_rd_err, 0);
  endtask

  // err_beat: 0-based beat answered with SLVERR (-1 none)
  // rst_beat: reset asserted while this 0-based beat is presented (-1 none)
  // junk_beat: extra start pulsed once this many beats are accepted (-1 none)
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len, input bit rnd,
                          input int err_beat, input int rst_beat, input int junk_beat);
    int total, nacc, slave_rem, fin_cyc, c1, n_ar, n_exp;
    bit pend_en, pend_err, junk_done, exp_err;
    logic [31:0] pend_data, cur_data;

    build_ars(addr, len);
    n_exp     = exp_addr.size();
    total     = int'(len / 4);
    nacc      = 0;
    slave_rem = 0;
    n_ar      = 0;
    pend_en   = 1'b0;
    pend_err  = 1'b0;
    pend_data = '0;
    junk_done = 1'b0;
    cur_data  = $urandom;
    exp_err   = ERR_EN && err_beat >= 0 && err_beat < total;

    @(negedge pl_clk); cyc++;
    pl_ddr_rd_start  = 1'b1;
    pl_ddr_rd_addr   = addr;
    pl_ddr_rd_length = len;
    m_arready = 1'b0; m_rvalid = 1'b0; pl_fifo_afull = 1'b0;
    @(negedge pl_clk); cyc++;
    pl_ddr_rd_start = 1'b0;
    c1 = cyc;
    chk("busy_start", pl_ddr_rd_busy, 1);
    chk("arvalid_start", m_arvalid, (total > 0));
    chk("err_cleared", pl_ddr_rd_err, 0);
    fin_cyc = (total == 0) ? c1 + 1 : -10;

    forever begin
      // output checks for the current cycle
      chk("rd_en", pl_ddr_rd_en, pend_en);
      if (pend_en) chk("rd_data", pl_ddr_rd_data, pend_data);
      if (pend_err) chk("err_set", pl_ddr_rd_err, ERR_EN);
      chk("finish", pl_ddr_rd_finish, (cyc == fin_cyc));
      if (cyc == fin_cyc) begin
        chk("busy_at_finish", pl_ddr_rd_busy, (total > 0));
        chk("err_at_finish", pl_ddr_rd_err, exp_err);
      end
      if (cyc == fin_cyc + 1) begin
        chk("busy_after", pl_ddr_rd_busy, 0);
        chk("arvalid_after", m_arvalid, 0);
        chk("beats", nacc, total);
        chk("ar_count", n_ar, n_exp);
        break;
      end
      if (cyc - c1 > 30000) begin
        chk("timeout_beats", nacc, total);
        break;
      end

      // drive slave and consumer for the next edge
      pl_ddr_rd_start = 1'b0;
      if (junk_beat >= 0 && !junk_done && nacc == junk_beat) begin
        pl_ddr_rd_start  = 1'b1;
        pl_ddr_rd_addr   = 32'h5550_0000;
        pl_ddr_rd_length = 32'h40;
        junk_done = 1'b1;
      end
      if (rst_beat >= 0 && nacc == rst_beat && slave_rem > 0) rst_n = 1'b0;
      m_arready     = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      pl_fifo_afull = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (slave_rem == 0)              m_rvalid = 1'b0;
      else if (!m_rvalid || pend_en)   m_rvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_rdata = cur_data;
      m_rlast = (slave_rem == 1);
      m_rresp = (nacc == err_beat) ? 2'd2 : 2'd0;
      #1;

      if (!rst_n) begin
        @(negedge pl_clk); cyc++;
        pl_fifo_afull = 1'b0;
        #1;
        chk_zero("midrst");
        rst_n = 1'b1; m_rvalid = 1'b0; m_arready = 1'b0;
        return;
      end

      if (pl_fifo_afull) chk("rready_afull", m_rready, 0);
      if (m_arvalid && m_arready) begin
        chk("one_outstanding", slave_rem, 0);
        if (n_ar < n_exp) begin
          chk("araddr", m_araddr, exp_addr[n_ar]);
          chk("arlen", m_arlen, exp_len[n_ar]);
        end
        n_ar++;
        slave_rem = int'(m_arlen) + 1;
      end
      pend_en  = 1'b0;
      pend_err = 1'b0;
      if (m_rvalid && m_rready) begin
        pend_en   = 1'b1;
        pend_data = m_rdata;
        pend_err  = (nacc == err_beat);
        nacc++;
        slave_rem--;
        cur_data = $urandom;
        if (nacc == total) fin_cyc = cyc + 1;
      end
      @(negedge pl_clk); cyc++;
    end
  endtask

  initial begin
    logic [31:0] ra, rl;
    rst_n = 1'b0;
    repeat (3) @(negedge pl_clk);
    cyc = 3;
    chk_zero("reset");
    rst_n = 1'b1;

    run_xfer(32'h0000_0000, 32'd32000, 1'b0, -1, -1, -1);
    run_xfer(32'h0000_0FF0, 32'd128,   1'b0, -1, -1, -1);
    run_xfer(32'h0000_0100, 32'd0,     1'b0, -1, -1, -1);
    ra = $urandom & 32'h00FF_FFFC;
    run_xfer(ra,            32'd1024,  1'b1, -1, -1, -1);
    run_xfer(32'h0000_0F80, 32'd256,   1'b1,  4, -1, 10);
    run_xfer(32'h0000_3000, 32'd64,    1'b1, -1, -1, -1);
    run_xfer(32'h0000_0040, 32'd256,   1'b0, -1,  6, -1);
    run_xfer(32'h0000_1FC0, 32'd200,   1'b1, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom & 32'h0FFF_FFFC;
      rl = 32'($urandom_range(0, 300)) * 4;
      run_xfer(ra, rl, 1'b1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
